// File: rtl/text_write_arbiter_if.sv
// rtl/text_write_arbiter_if.sv - request and Font_ROM write-port bundle for text_write_arbiter
interface text_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int COLUMNS = 16,
  parameter int ROWS    = 19
);
  localparam int XW = $clog2(COLUMNS);
  localparam int YW = $clog2(ROWS);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          i_req_valid;
  logic [NUM_REQ-1:0][7:0]     i_req_char;
  logic [NUM_REQ-1:0][XW-1:0]  i_req_x;
  logic [NUM_REQ-1:0][YW-1:0]  i_req_y;
  logic [NUM_REQ-1:0]          o_req_ready;
  logic                        o_wr_en;
  logic [7:0]                  o_wr_character;
  logic [XW-1:0]               o_wr_x_pos;
  logic [YW-1:0]               o_wr_y_pos;
  logic [GW-1:0]               o_grant_id;
  logic                        o_drop;

  modport slave (
    input  i_req_valid, i_req_char, i_req_x, i_req_y,
    output o_req_ready, o_wr_en, o_wr_character, o_wr_x_pos, o_wr_y_pos,
           o_grant_id, o_drop
  );

  modport master (
    output i_req_valid, i_req_char, i_req_x, i_req_y,
    input  o_req_ready, o_wr_en, o_wr_character, o_wr_x_pos, o_wr_y_pos,
           o_grant_id, o_drop
  );
endinterface

// File: rtl/text_write_arbiter.sv
// rtl/text_write_arbiter.sv - round-robin arbiter for the Font_ROM character write port
// Optional buffer clear sequencer enabled by TEXT_ARB_CLEAR_EN.
module text_write_arbiter #(
  parameter int         NUM_REQ    = 2,
  parameter int         COLUMNS    = 16,
  parameter int         ROWS       = 19,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  text_write_arbiter_if.slave   bus
`ifdef TEXT_ARB_CLEAR_EN
  ,
  input  logic                  i_clear,
  output logic                  o_clear_busy
`endif
);
  localparam int XW = $clog2(COLUMNS);
  localparam int YW = $clog2(ROWS);
  localparam int GW = $clog2(NUM_REQ);
  // One extra bit so the limit is representable even when COLUMNS/ROWS are powers of two
  localparam logic [XW:0]   X_LIM  = (XW+1)'(COLUMNS);
  localparam logic [YW:0]   Y_LIM  = (YW+1)'(ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(COLUMNS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  logic [GW-1:0] ptr_q, ptr_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    char_q, char_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [GW-1:0] gid_q, gid_d;
  logic          drop_q, drop_d;

  logic          grant_found;
  logic [GW-1:0] grant_sel;
  logic [GW-1:0] scan_idx;
  logic          arb_en;
  logic          take;
  logic [7:0]    sel_char;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic          in_range;

`ifdef TEXT_ARB_CLEAR_EN
  typedef enum logic {ST_ARB, ST_CLEAR} state_e;
  state_e state_q, state_d;

  assign arb_en       = i_rst_n && (state_q == ST_ARB) && !i_clear;
  assign o_clear_busy = (state_q == ST_CLEAR);
`else
  assign arb_en = i_rst_n;
`endif

  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = GW'((int'(ptr_q) + i) % NUM_REQ);
      if (!grant_found && bus.i_req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_sel   = scan_idx;
      end
    end
  end

  assign take     = grant_found && arb_en;
  assign sel_char = bus.i_req_char[grant_sel];
  assign sel_x    = bus.i_req_x[grant_sel];
  assign sel_y    = bus.i_req_y[grant_sel];
  assign in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);

  always_comb begin
    bus.o_req_ready = '0;
    if (take) bus.o_req_ready = NUM_REQ'(1) << grant_sel;
  end

  always_comb begin
    ptr_d   = ptr_q;
    wr_en_d = 1'b0;
    drop_d  = 1'b0;
    char_d  = char_q;
    x_d     = x_q;
    y_d     = y_q;
    gid_d   = gid_q;
`ifdef TEXT_ARB_CLEAR_EN
    state_d = state_q;
`endif
    if (take) begin
      ptr_d = GW'((int'(grant_sel) + 1) % NUM_REQ);
      gid_d = grant_sel;
      if (in_range) begin
        wr_en_d = 1'b1;
        char_d  = sel_char;
        x_d     = sel_x;
        y_d     = sel_y;
      end else begin
        drop_d = 1'b1;
      end
    end
`ifdef TEXT_ARB_CLEAR_EN
    // The write registers double as the clear cell counter; cell 0 is loaded on entry
    case (state_q)
      ST_ARB: begin
        if (i_clear) begin
          state_d = ST_CLEAR;
          wr_en_d = 1'b1;
          char_d  = CLEAR_CHAR;
          x_d     = '0;
          y_d     = '0;
          gid_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = ST_ARB;
        end else begin
          wr_en_d = 1'b1;
          char_d  = CLEAR_CHAR;
          gid_d   = '0;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      wr_en_q <= 1'b0;
      char_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      gid_q   <= '0;
      drop_q  <= 1'b0;
`ifdef TEXT_ARB_CLEAR_EN
      state_q <= ST_ARB;
`endif
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      char_q  <= char_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gid_q   <= gid_d;
      drop_q  <= drop_d;
`ifdef TEXT_ARB_CLEAR_EN
      state_q <= state_d;
`endif
    end
  end

  assign bus.o_wr_en        = wr_en_q;
  assign bus.o_wr_character = char_q;
  assign bus.o_wr_x_pos     = x_q;
  assign bus.o_wr_y_pos     = y_q;
  assign bus.o_grant_id     = gid_q;
  assign bus.o_drop         = drop_q;
endmodule
